// File: rtl/r_arb_pkg.sv
// Shared types for the crossbar R-channel arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter state enum and AXI RRESP encodings.
package r_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

endpackage

// File: rtl/r_arbiter_if.sv
// AXI R channel bundle between the arbiter and one master port.
// Latency: n/a (wires only).
// Backpressure: RREADY from the master side, RVALID from the arbiter side.
// Modports: slave drives the R payload and RVALID, master drives RREADY.
interface r_arbiter_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave  (output RID, RDATA, RRESP, RLAST, RVALID, input  RREADY);
  modport master (input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY);
endinterface

// File: rtl/r_arbiter_rr_picker.sv
// Round-robin picker: first set req bit scanning ptr, ptr+1, ... mod N.
// Latency: combinational.
// Backpressure: none; found=0 when no request is set.
// Ports: req (N requests), ptr (scan start), found, idx (winning index).
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  // One spare bit so ptr+k cannot overflow before the explicit wrap,
  // which keeps the modulo correct for non-power-of-2 N.
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/r_arbiter.sv
// Round-robin R-channel arbiter, grant locked for a whole burst until RLAST.
// Latency: 1 cycle arbitration in IDLE, then 1 beat/cycle; 1 bubble between bursts.
// Backpressure: RREADY pops the granted FIFO combinationally; RVALID low waits.
// Ports: ACLK/ARESETn, per-source FIFO heads (src_*), src_pop, master R channel r, busy.
module r_arbiter
  import r_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*ID_WIDTH-1:0]   src_RID,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_RDATA,
  input  logic [NUM_SRC*2-1:0]          src_RRESP,
  input  logic [NUM_SRC-1:0]            src_RLAST,
  output logic [NUM_SRC-1:0]            src_pop,
  r_arbiter_if.slave                    r,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_SRC);

  state_t        state;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic          rvalid;
  logic          hs;

  logic [ID_WIDTH-1:0]   head_id   [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];
  logic [1:0]            head_resp [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign head_id[i]   = src_RID[i*ID_WIDTH +: ID_WIDTH];
    assign head_data[i] = src_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign head_resp[i] = src_RRESP[i*2 +: 2];
  end

  rr_picker #(.N(NUM_SRC), .PW(PW)) u_pick (
    .req   (~src_empty),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Gated by ARESETn so a reset landing mid-burst can never pop a FIFO.
  assign rvalid = ARESETn && (state == BURST) && !src_empty[grant];
  assign hs     = rvalid && r.RREADY;

  always_comb begin
    src_pop        = '0;
    src_pop[grant] = hs;
  end

  assign r.RVALID = rvalid;
  assign r.RID    = rvalid ? head_id[grant]   : '0;
  assign r.RDATA  = rvalid ? head_data[grant] : '0;
  assign r.RRESP  = rvalid ? head_resp[grant] : 2'b00;
  assign r.RLAST  = rvalid && src_RLAST[grant];
  assign busy     = (state == BURST);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= BURST;
          end
        end
        BURST: begin
          // Only the RLAST handshake releases the lock; an empty granted
          // FIFO simply stalls here.
          if (hs && src_RLAST[grant]) begin
            state  <= IDLE;
            rr_ptr <= (grant == PW'(NUM_SRC-1)) ? '0 : grant + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_arbiter.sv
// Directed bench for r_arbiter with per-source FIFO models.
// Latency: n/a.
// Backpressure: RREADY driven directly by the stimulus.
module tb_r_arbiter;
  import r_arb_pkg::*;

  localparam int NS = 4;
  localparam int IW = 4;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic              ARESETn;
  logic [NS-1:0]     src_empty;
  logic [NS*IW-1:0]  src_RID;
  logic [NS*DW-1:0]  src_RDATA;
  logic [NS*2-1:0]   src_RRESP;
  logic [NS-1:0]     src_RLAST;
  logic [NS-1:0]     src_pop;
  logic              busy;

  r_arbiter_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) rif ();

  r_arbiter #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .src_empty (src_empty),
    .src_RID   (src_RID),
    .src_RDATA (src_RDATA),
    .src_RRESP (src_RRESP),
    .src_RLAST (src_RLAST),
    .src_pop   (src_pop),
    .r         (rif.slave),
    .busy      (busy)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t mem [NS][32];
  int    wr_p [NS];
  int    rd_p [NS];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      if (rd_p[i] == wr_p[i]) begin
        src_empty[i] = 1'b1;
        b = '0;
      end else begin
        src_empty[i] = 1'b0;
        b = mem[i][rd_p[i] % 32];
      end
      src_RID[i*IW +: IW]   = b.id;
      src_RDATA[i*DW +: DW] = b.data;
      src_RRESP[i*2 +: 2]   = b.resp;
      src_RLAST[i]          = b.last;
    end
  endtask

  task automatic push(input int s, input logic [IW-1:0] id, input logic [DW-1:0] data,
                      input logic [1:0] resp, input logic last);
    mem[s][wr_p[s] % 32] = '{id: id, data: data, resp: resp, last: last};
    wr_p[s]++;
  endtask

  task automatic burst(input int s, input logic [IW-1:0] id, input logic [DW-1:0] base,
                       input int n, input logic [1:0] resp);
    for (int k = 0; k < n; k++) push(s, id, base + DW'(k), resp, (k == n-1));
  endtask

  // Advance one clock; the FIFO models pop on the pops seen before the edge.
  task automatic tick();
    logic [NS-1:0] p;
    p = src_pop;
    @(posedge ACLK);
    for (int i = 0; i < NS; i++)
      if (p[i] && rd_p[i] < wr_p[i]) rd_p[i]++;
    #1;
    refresh();
  endtask

  task automatic check_idle(input string tag, input logic busy_exp);
    @(negedge ACLK);
    chk({tag, ".rvalid"}, 64'(rif.RVALID), 64'(1'b0));
    chk({tag, ".pop"},    64'(src_pop),    64'(4'b0000));
    chk({tag, ".rdata"},  64'(rif.RDATA),  64'(0));
    chk({tag, ".rlast"},  64'(rif.RLAST),  64'(1'b0));
    chk({tag, ".busy"},   64'(busy),       64'(busy_exp));
  endtask

  task automatic check_beat(input string tag, input logic [IW-1:0] id, input logic [DW-1:0] data,
                            input logic [1:0] resp, input logic last, input logic [NS-1:0] pop);
    @(negedge ACLK);
    chk({tag, ".rvalid"}, 64'(rif.RVALID), 64'(1'b1));
    chk({tag, ".rid"},    64'(rif.RID),    64'(id));
    chk({tag, ".rdata"},  64'(rif.RDATA),  64'(data));
    chk({tag, ".rresp"},  64'(rif.RRESP),  64'(resp));
    chk({tag, ".rlast"},  64'(rif.RLAST),  64'(last));
    chk({tag, ".pop"},    64'(src_pop),    64'(pop));
    chk({tag, ".busy"},   64'(busy),       64'(1'b1));
  endtask

  initial begin
    ARESETn    = 1'b0;
    rif.RREADY = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    refresh();
    #1;

    // Reset: first cycle only the gated outputs are defined.
    @(negedge ACLK);
    chk("rst0.rvalid", 64'(rif.RVALID), 64'(1'b0));
    chk("rst0.pop",    64'(src_pop),    64'(4'b0000));
    chk("rst0.rdata",  64'(rif.RDATA),  64'(0));
    tick();
    check_idle("rst1", 1'b0);
    tick();
    ARESETn = 1'b1;

    // All sources empty for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      check_idle($sformatf("empty%0d", c), 1'b0);
      tick();
    end

    // Source 2, 4-beat burst, RREADY=1.
    rif.RREADY = 1'b1;
    burst(2, 4'h5, 32'h10, 4, RRESP_OKAY);
    refresh();
    check_idle("s2.arb", 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_beat($sformatf("s2.b%0d", k), 4'h5, 32'h10 + k, RRESP_OKAY, (k == 3), 4'b0100);
      tick();
    end
    check_idle("s2.end", 1'b0);
    tick();

    // Reset to rr_ptr=0, then sources 0 and 3 compete.
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    burst(0, 4'h1, 32'h20, 2, RRESP_OKAY);
    burst(3, 4'h2, 32'h30, 2, RRESP_EXOKAY);
    refresh();
    check_idle("rr.arb", 1'b0);
    tick();
    check_beat("rr.s0b0", 4'h1, 32'h20, RRESP_OKAY, 1'b0, 4'b0001); tick();
    check_beat("rr.s0b1", 4'h1, 32'h21, RRESP_OKAY, 1'b1, 4'b0001); tick();
    check_idle("rr.bubble", 1'b0); tick();
    check_beat("rr.s3b0", 4'h2, 32'h30, RRESP_EXOKAY, 1'b0, 4'b1000); tick();
    check_beat("rr.s3b1", 4'h2, 32'h31, RRESP_EXOKAY, 1'b1, 4'b1000); tick();

    // rr_ptr wrapped to 0: source 0 beats source 1; single-beat bursts.
    push(0, 4'h3, 32'hA0, RRESP_OKAY, 1'b1);
    push(1, 4'h4, 32'hB0, RRESP_DECERR, 1'b1);
    refresh();
    check_idle("wrap.arb", 1'b0); tick();
    check_beat("wrap.s0", 4'h3, 32'hA0, RRESP_OKAY, 1'b1, 4'b0001); tick();
    check_idle("wrap.bubble", 1'b0); tick();
    check_beat("wrap.s1", 4'h4, 32'hB0, RRESP_DECERR, 1'b1, 4'b0010); tick();
    check_idle("wrap.end", 1'b0); tick();

    // Backpressure mid-burst on source 1 (rr_ptr=2, scan wraps to 1).
    burst(1, 4'h6, 32'h40, 4, RRESP_SLVERR);
    refresh();
    check_idle("bp.arb", 1'b0); tick();
    check_beat("bp.b0", 4'h6, 32'h40, RRESP_SLVERR, 1'b0, 4'b0010); tick();
    rif.RREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk($sformatf("bp.hold%0d.rvalid", c), 64'(rif.RVALID), 64'(1'b1));
      chk($sformatf("bp.hold%0d.rdata", c),  64'(rif.RDATA),  64'(32'h41));
      chk($sformatf("bp.hold%0d.pop", c),    64'(src_pop),    64'(4'b0000));
      tick();
    end
    rif.RREADY = 1'b1;
    for (int k = 1; k < 4; k++) begin
      check_beat($sformatf("bp.b%0d", k), 4'h6, 32'h40 + k, RRESP_SLVERR, (k == 3), 4'b0010);
      tick();
    end
    check_idle("bp.end", 1'b0); tick();

    // Underflow on source 2 while source 1 waits.
    push(2, 4'h7, 32'h50, RRESP_OKAY, 1'b0);
    push(2, 4'h7, 32'h51, RRESP_OKAY, 1'b0);
    push(1, 4'h8, 32'h60, RRESP_OKAY, 1'b1);
    refresh();
    check_idle("uf.arb", 1'b0); tick();
    check_beat("uf.b0", 4'h7, 32'h50, RRESP_OKAY, 1'b0, 4'b0100); tick();
    check_beat("uf.b1", 4'h7, 32'h51, RRESP_OKAY, 1'b0, 4'b0100); tick();
    for (int c = 0; c < 2; c++) begin
      check_idle($sformatf("uf.stall%0d", c), 1'b1);
      tick();
    end
    push(2, 4'h7, 32'h52, RRESP_OKAY, 1'b0);
    push(2, 4'h7, 32'h53, RRESP_OKAY, 1'b1);
    refresh();
    check_beat("uf.b2", 4'h7, 32'h52, RRESP_OKAY, 1'b0, 4'b0100); tick();
    check_beat("uf.b3", 4'h7, 32'h53, RRESP_OKAY, 1'b1, 4'b0100); tick();
    check_idle("uf.bubble", 1'b0); tick();
    check_beat("uf.s1", 4'h8, 32'h60, RRESP_OKAY, 1'b1, 4'b0010); tick();
    check_idle("uf.end", 1'b0); tick();

    // Reset during beat 2 of a 4-beat burst on source 2.
    burst(2, 4'h9, 32'h80, 4, RRESP_OKAY);
    refresh();
    check_idle("mr.arb", 1'b0); tick();
    check_beat("mr.b0", 4'h9, 32'h80, RRESP_OKAY, 1'b0, 4'b0100); tick();
    ARESETn = 1'b0;
    push(0, 4'hA, 32'h90, RRESP_OKAY, 1'b1);
    refresh();
    @(negedge ACLK);
    chk("mr.rst.rvalid", 64'(rif.RVALID), 64'(1'b0));
    chk("mr.rst.pop",    64'(src_pop),    64'(4'b0000));
    chk("mr.rst.rdata",  64'(rif.RDATA),  64'(0));
    tick();
    ARESETn = 1'b1;
    check_idle("mr.after", 1'b0); tick();
    check_beat("mr.s0", 4'hA, 32'h90, RRESP_OKAY, 1'b1, 4'b0001); tick();
    check_idle("mr.bubble", 1'b0); tick();
    for (int k = 1; k < 4; k++) begin
      check_beat($sformatf("mr.s2b%0d", k), 4'h9, 32'h80 + k, RRESP_OKAY, (k == 3), 4'b0100);
      tick();
    end
    check_idle("mr.end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/r_arbiter.md
# r_arbiter

Master-side R-channel arbiter for the crossbar. It consumes the heads of NUM_SRC per-slave R response FIFOs, each exposing front_* outputs plus empty and taking a pop input. It presents a single AXI R channel toward one master port. Arbitration is round-robin, and a grant is locked for a full burst until the RLAST beat, so beats of different bursts never interleave on the master port.

## Interface
- ID_WIDTH, 4, RID width
- DATA_WIDTH, 32, RDATA width
- NUM_SRC, 4, number of source FIFOs; ≥2, need not be a power of 2
- ACLK  in  1  clock; all state updates on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- src_empty  in  NUM_SRC  per-source FIFO empty
- src_RID  in  NUM_SRC*ID_WIDTH  flattened FIFO heads; source i at bits [i*ID_WIDTH +: ID_WIDTH]
- src_RDATA  in  NUM_SRC*DATA_WIDTH  flattened heads, same packing
- src_RRESP  in  NUM_SRC*2  flattened heads
- src_RLAST  in  NUM_SRC  heads
- src_pop  out  NUM_SRC  one-hot or zero; pops the granted FIFO
- RID  out  ID_WIDTH  master R channel
- RDATA  out  DATA_WIDTH  master R channel
- RRESP  out  2  master R channel
- RLAST  out  1  master R channel
- RVALID  out  1  master R channel
- RREADY  in  1  master R channel
- busy  out  1  high while in BURST

## Operation
- State machine with two states: IDLE and BURST. Registers: state, grant (index, $clog2(NUM_SRC) bits), rr_ptr (same width).
- IDLE:
  - If any src_empty bit is 0, pick the first non-empty source scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - Register it into grant and go to BURST.
  - RVALID=0 and src_pop=0 throughout IDLE.
- BURST:
  - RVALID = ~src_empty[grant].
  - RID/RDATA/RRESP/RLAST = heads of the granted source when RVALID=1, else all zero.
- Handshake: a beat transfers when RVALID & RREADY. src_pop[grant] = RVALID & RREADY, combinational and the same cycle. No other src_pop bit is ever asserted.
- On a handshake with RLAST=1:
  - Next state IDLE.
  - rr_ptr ← grant+1, wrapping to 0 when grant = NUM_SRC-1.
- A handshake with RLAST=0 keeps BURST and keeps grant.
- If the granted FIFO empties mid-burst, RVALID drops and the arbiter stays locked and waits. Other sources are not serviced until the RLAST beat.
- AXI stability holds by construction: while RVALID=1 and RREADY=0, no pop occurs and grant is fixed, so payload is stable.
- busy = (state==BURST).

## Timing
- Reset: state=IDLE, grant=0, rr_ptr=0. All outputs 0 (RVALID, RLAST, RID, RDATA, RRESP, src_pop, busy).
- Reset applied mid-burst aborts the burst: the next cycle is IDLE with rr_ptr=0, and no pop is issued in the reset cycle.
- Arbitration latency: 1 cycle. A source that becomes non-empty in cycle t (arbiter in IDLE) can first have RVALID=1 in cycle t+1.
- Throughput: 1 beat/cycle within a burst. 1 idle bubble cycle between bursts, spent in IDLE.
- Single-beat burst (RLAST on first beat): BURST for 1 cycle when RREADY=1, then IDLE.
- RREADY is ignored while RVALID=0.
- All decisions use current-cycle inputs; only state, grant and rr_ptr are registered. The RREADY→src_pop path is combinational.

## Structure
- Package r_arb_pkg: state enum {IDLE, BURST} and RRESP constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR).
- Sub-module rr_picker: combinational; inputs req[NUM_SRC] and ptr; outputs found and idx, with modulo wrap for non-power-of-2 NUM_SRC. It is reused by the AW/AR arbiters.
- Remaining logic (FSM, grant/pointer registers, payload mux, pop decode) lives in r_arbiter.

## Test plan
- Reset, then all sources empty for 10 cycles → RVALID=0, src_pop=0, busy=0 every cycle.
- Source 2 holds a 4-beat burst (RID=4'h5, RDATA=0x10..0x13), RREADY=1 → RVALID rises 1 cycle after the non-empty cycle. 4 consecutive beats with RDATA in order, RLAST only on 0x13, src_pop=4'b0100 on each beat, then IDLE.
- Sources 0 and 3 each hold a 2-beat burst with rr_ptr=0 → source 0 is served, then one bubble, then source 3 (rr_ptr=1 scan wraps to 3). After that rr_ptr=0.
- Backpressure: RREADY=0 for 3 cycles mid-burst → RVALID stays 1, payload unchanged, src_pop=0. Transfer resumes when RREADY=1.
- Granted FIFO underflows mid-burst while source 1 is non-empty → RVALID=0 and no switch to source 1 until the granted burst's RLAST beat completes.
- Reset asserted during beat 2 of a 4-beat burst → next cycle all outputs are 0 and IDLE. After release, arbitration restarts from source 0.
